// File: rtl/pipe_event_counter.sv
// Pipeline performance monitor: run-cycle counter plus NUM_EVT event counters.
// Optional macro PERF_EDGE_COUNT_EN: count rising edges of event_i instead of levels.
module pipe_event_counter #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    localparam int SEL_W     = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               freeze_i,
    input  logic [NUM_EVT-1:0] event_i,
    input  logic               snap_i,
    input  logic               rd_shadow_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic [1:0]         state_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FROZEN = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    // Index NUM_EVT of the counter banks is the run-cycle counter.
    localparam int CYC = NUM_EVT;

    // The limit is only reachable when it fits in the counter width.
    localparam longint MAX_CNT = (longint'(1) << CNT_W) - 1;
    localparam bit LIM_EN = (MAX_CYCLES > 0) && (longint'(MAX_CYCLES) <= MAX_CNT);
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q    [NUM_EVT+1];
    logic [CNT_W-1:0] cnt_d    [NUM_EVT+1];
    logic [CNT_W-1:0] shadow_q [NUM_EVT+1];
    logic [NUM_EVT:0] ovf_q, ovf_d;
    logic [CNT_W-1:0] rd_q, rd_d;

    logic [NUM_EVT-1:0] hit;
    logic [NUM_EVT:0]   inc;
    logic               count_en;
    logic               lim_hit;

`ifdef PERF_EDGE_COUNT_EN
    logic [NUM_EVT-1:0] prev_q;

    // Previous event sample for rising-edge detection, tracked in every state.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= event_i;
        end
    end

    assign hit = event_i & ~prev_q;
`else
    assign hit = event_i;
`endif

    assign count_en = (state_q == S_RUN) && !freeze_i && !clear_i;
    assign inc      = {count_en, hit & {NUM_EVT{count_en}}};
    assign lim_hit  = LIM_EN && count_en && (cnt_q[CYC] == LIM_M1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats freeze, freeze beats start and counting.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!freeze_i && start_i) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (freeze_i) begin
                        state_d = S_FROZEN;
                    end else if (lim_hit) begin
                        state_d = S_DONE;
                    end
                end
                S_FROZEN: begin
                    if (!freeze_i) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        state_o = state_q;
        done_o  = (state_q == S_DONE);
    end

    // Saturating increments with sticky overflow; clear zeroes the live bank.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (inc[k]) begin
                if (&cnt_q[k]) begin
                    ovf_d[k] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + ONE;
                end
            end
        end
        if (clear_i) begin
            for (int k = 0; k <= NUM_EVT; k++) begin
                cnt_d[k] = '0;
            end
            ovf_d = '0;
        end
    end

    // Read mux over pre-edge register values; out-of-range selects read 0.
    always_comb begin
        rd_d = '0;
        if (rd_sel_i <= SEL_W'(NUM_EVT)) begin
            rd_d = rd_shadow_i ? shadow_q[rd_sel_i] : cnt_q[rd_sel_i];
        end
    end

    // Live bank, shadow snapshot, overflow flags and read register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_EVT; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
            ovf_q <= '0;
            rd_q  <= '0;
        end else begin
            if (snap_i) begin
                shadow_q <= cnt_q;
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            rd_q  <= rd_d;
        end
    end

    assign rd_data_o = rd_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pipe_event_counter.sv
// Bench for pipe_event_counter: directed scenarios plus random traffic,
// two instances (32-bit with limit 64, 4-bit unlimited) against a reference model.
module tb_pipe_event_counter;

`ifdef PERF_EDGE_COUNT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] ev = '0;
    logic       snap = 1'b0;
    logic       rd_shadow = 1'b0;
    logic [2:0] rd_sel = '0;

    logic [31:0] rd_a;
    logic [4:0]  ovf_a;
    logic [1:0]  st_a;
    logic        done_a;
    logic [3:0]  rd_b;
    logic [4:0]  ovf_b;
    logic [1:0]  st_b;
    logic        done_b;

    int n_chk = 0;
    int n_fail = 0;

    pipe_event_counter #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(64)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .freeze_i(freeze), .event_i(ev), .snap_i(snap),
        .rd_shadow_i(rd_shadow), .rd_sel_i(rd_sel),
        .rd_data_o(rd_a), .ovf_o(ovf_a), .state_o(st_a), .done_o(done_a)
    );

    pipe_event_counter #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
        .freeze_i(freeze), .event_i(ev), .snap_i(snap),
        .rd_shadow_i(rd_shadow), .rd_sel_i(rd_sel),
        .rd_data_o(rd_b), .ovf_o(ovf_b), .state_o(st_b), .done_o(done_b)
    );

    always #5 clk = ~clk;

    // Reference model: integer counters, states 0 idle 1 run 2 frozen 3 done.
    longint     cnt  [2][5];
    longint     sh   [2][5];
    logic [4:0] movf [2];
    int         mst  [2];
    longint     mrd  [2];
    logic [3:0] mprev[2];
    longint     maxv [2] = '{64'd4294967295, 64'd15};
    longint     lim  [2] = '{64, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic bump(input int m, input int k);
        if (cnt[m][k] == maxv[m]) movf[m][k] = 1'b1;
        else cnt[m][k] = cnt[m][k] + 1;
    endtask

    task automatic model_step(input int m);
        int sel;
        sel = int'(rd_sel);
        if (rst) begin
            for (int k = 0; k < 5; k++) begin
                cnt[m][k] = 0;
                sh[m][k] = 0;
            end
            movf[m] = '0;
            mst[m] = 0;
            mrd[m] = 0;
            mprev[m] = '0;
            return;
        end
        mrd[m] = 0;
        if (sel <= 4) mrd[m] = rd_shadow ? sh[m][sel] : cnt[m][sel];
        if (snap) begin
            for (int k = 0; k < 5; k++) sh[m][k] = cnt[m][k];
        end
        if (clear) begin
            for (int k = 0; k < 5; k++) cnt[m][k] = 0;
            movf[m] = '0;
            mst[m] = 0;
            mprev[m] = '0;
        end else begin
            case (mst[m])
                0: if (!freeze && start) mst[m] = 1;
                1: begin
                    if (freeze) begin
                        mst[m] = 2;
                    end else begin
                        bump(m, 4);
                        for (int k = 0; k < 4; k++) begin
                            if (ev[k] && !(EDGE && mprev[m][k])) bump(m, k);
                        end
                        if (lim[m] != 0 && cnt[m][4] == lim[m]) mst[m] = 3;
                    end
                end
                2: if (!freeze) mst[m] = 1;
                default: ;
            endcase
            mprev[m] = ev;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("st_a", 64'(st_a), 64'(mst[0]));
        chk("done_a", 64'(done_a), 64'(mst[0] == 3));
        chk("ovf_a", 64'(ovf_a), 64'(movf[0]));
        chk("rd_a", 64'(rd_a), 64'(mrd[0]));
        chk("st_b", 64'(st_b), 64'(mst[1]));
        chk("done_b", 64'(done_b), 64'(mst[1] == 3));
        chk("ovf_b", 64'(ovf_b), 64'(movf[1]));
        chk("rd_b", 64'(rd_b), 64'(mrd[1]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic restart();
        ev = '0;
        freeze = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_a(input logic [2:0] sel, input logic shd);
        rd_sel = sel;
        rd_shadow = shd;
        tick();
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        chk("rst_state", 64'(st_a), 64'd0);
        chk("rst_rd", 64'(rd_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        rst = 1'b0;

        // 1: level event 0 for 10 run cycles
        restart();
        ev = 4'b0001;
        ticks(10);
        ev = '0;
        freeze = 1'b1;
        tick();
        read_a(3'd4, 1'b0);
        chk("t1_cyc", 64'(rd_a), 64'd10);
        read_a(3'd0, 1'b0);
        chk("t1_evt0", 64'(rd_a), EDGE ? 64'd1 : 64'd10);
        for (int k = 1; k < 4; k++) begin
            read_a(3'(k), 1'b0);
            chk("t1_evtk", 64'(rd_a), 64'd0);
        end

        // 2: freeze in the middle of a run
        restart();
        ev = 4'b0011;
        ticks(5);
        freeze = 1'b1;
        ticks(3);
        chk("t2_frozen", 64'(st_a), 64'd2);
        freeze = 1'b0;
        ticks(6);
        freeze = 1'b1;
        tick();
        read_a(3'd4, 1'b0);
        chk("t2_cyc", 64'(rd_a), 64'd10);
        read_a(3'd1, 1'b0);
        chk("t2_evt1", 64'(rd_a), EDGE ? 64'd1 : 64'd10);

        // 3 and 4: cycle limit on instance a, saturation on instance b
        restart();
        ev = 4'b0100;
        ticks(63);
        chk("t3_not_done", 64'(done_a), 64'd0);
        tick();
        chk("t3_done", 64'(done_a), 64'd1);
        start = 1'b1;
        ticks(9);
        start = 1'b0;
        read_a(3'd4, 1'b0);
        chk("t3_cyc_hold", 64'(rd_a), 64'd64);
        chk("t3_state", 64'(st_a), 64'd3);
        read_a(3'd2, 1'b0);
        chk("t3_evt2", 64'(rd_a), EDGE ? 64'd1 : 64'd64);
        chk("t4_evt2_sat", 64'(rd_b), EDGE ? 64'd1 : 64'd15);
        chk("t4_ovf2", 64'(ovf_b[2]), EDGE ? 64'd0 : 64'd1);
        chk("t4_ovf_cyc", 64'(ovf_b[4]), 64'd1);
        ev = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t3_clr_state", 64'(st_a), 64'd0);
        chk("t3_clr_done", 64'(done_a), 64'd0);
        chk("t4_clr_ovf", 64'(ovf_b), 64'd0);
        read_a(3'd4, 1'b0);
        chk("t3_clr_cyc", 64'(rd_a), 64'd0);

        // 5: snapshot and clear on the same edge
        restart();
        ticks(37);
        snap = 1'b1;
        clear = 1'b1;
        tick();
        snap = 1'b0;
        clear = 1'b0;
        read_a(3'd4, 1'b1);
        chk("t5_shadow", 64'(rd_a), 64'd37);
        read_a(3'd4, 1'b0);
        chk("t5_live", 64'(rd_a), 64'd0);
        read_a(3'd5, 1'b1);
        chk("t5_badsel", 64'(rd_a), 64'd0);

        // 6: pulse train on event 1
        restart();
        ev = 4'b0010;
        ticks(5);
        ev = '0;
        ticks(2);
        ev = 4'b0010;
        ticks(5);
        ev = '0;
        freeze = 1'b1;
        tick();
        read_a(3'd1, 1'b0);
        chk("t6_evt1", 64'(rd_a), EDGE ? 64'd2 : 64'd10);

        // Random traffic
        freeze = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) freeze = ~freeze;
            start     = ($urandom_range(0, 3) == 0);
            snap      = ($urandom_range(0, 7) == 0);
            ev        = 4'($urandom);
            rd_shadow = 1'($urandom);
            rd_sel    = 3'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
